// File: rtl/lidar_pkg.sv
// Shared types and defaults for the point-cloud BRAM port arbiter and the
// cache logic that feeds it.
package lidar_pkg;
  localparam int BUS_SIZE_DEF   = 32;
  localparam int BRAM_SHIFT_DEF = 2;

  localparam logic TAG_CORE = 1'b1;
  localparam logic TAG_FEED = 1'b0;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_WRITE} arb_state_e;

  typedef struct packed {
    logic vld;
    logic is_core;
  } tag_t;
endpackage

// File: rtl/read_tag_pipe.sv
// Tag shift register that follows each read through the BRAM so its data
// is returned only to the requester that issued it.
module read_tag_pipe
  import lidar_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic clock,
  input  logic reset,
  input  tag_t push_tag,
  output logic rd_capture,
  output logic rvalid_core,
  output logic rvalid_feed,
  output logic empty
);
  localparam int DEPTH = 1 + READ_LATENCY;

  tag_t [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d[0] = push_tag;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  // read_out belongs to the tag one stage before the output stage
  assign rd_capture  = pipe_q[READ_LATENCY-1].vld;
  assign rvalid_core = pipe_q[DEPTH-1].vld & (pipe_q[DEPTH-1].is_core == TAG_CORE);
  assign rvalid_feed = pipe_q[DEPTH-1].vld & (pipe_q[DEPTH-1].is_core == TAG_FEED);

  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) if (pipe_q[i].vld) empty = 1'b0;
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// One-access-per-cycle arbiter for the shared x/y/z point-cloud BRAM port:
// core refill reads, feeder reads (with anti-starvation) and zeroing writes.
module bram_port_arbiter
  import lidar_pkg::*;
#(
  parameter int BUS_SIZE     = BUS_SIZE_DEF,
  parameter int WORD_W       = 16,
  parameter int BRAM_SHIFT   = BRAM_SHIFT_DEF,
  parameter int READ_LATENCY = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                pause,
  input  logic                req_core,
  input  logic [WORD_W-1:0]   core_word,
  output logic                gnt_core,
  input  logic                req_feed,
  input  logic [WORD_W-1:0]   feed_word,
  output logic                gnt_feed,
  input  logic                req_wb,
  input  logic [WORD_W-1:0]   wb_word,
  output logic                gnt_wb,
  output logic [31:0]         addr_x, addr_y, addr_z,
  output logic                en_x, en_y, en_z,
  output logic [3:0]          we_x, we_y, we_z,
  output logic [BUS_SIZE-1:0] write_in_x, write_in_y, write_in_z,
  output logic                rst_x, rst_y, rst_z,
  input  logic [BUS_SIZE-1:0] read_out_x, read_out_y, read_out_z,
  output logic [BUS_SIZE-1:0] rdata_x, rdata_y, rdata_z,
  output logic                rvalid_core,
  output logic                rvalid_feed,
  output logic                busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state_q, state_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [31:0]         addr_q, addr_d;
  logic                en_q, en_d;
  logic [3:0]          we_q, we_d;
  logic [BUS_SIZE-1:0] rdx_q, rdx_d, rdy_q, rdy_d, rdz_q, rdz_d;
  logic                can_issue, feed_forced, gnt_rd, pipe_empty, rd_capture;
  tag_t                push_tag;

  function automatic logic [31:0] word_addr(input logic [WORD_W-1:0] w);
    return 32'(w) << BRAM_SHIFT;
  endfunction

  // Reads are held off whenever a write-back is waiting, so the pipe drains
  always_comb begin
    can_issue   = !pause && !reset;
    feed_forced = (starve_q == SW'(STARVE_LIMIT));
    gnt_wb      = can_issue && req_wb && pipe_empty;
    gnt_feed    = can_issue && !req_wb && req_feed && (feed_forced || !req_core);
    gnt_core    = can_issue && !req_wb && req_core && !(req_feed && feed_forced);
    gnt_rd      = gnt_core || gnt_feed;
  end

  always_comb begin
    addr_d   = addr_q;
    en_d     = 1'b0;
    we_d     = 4'h0;
    push_tag = '{vld: gnt_rd, is_core: gnt_core ? TAG_CORE : TAG_FEED};
    if (gnt_wb) begin
      addr_d = word_addr(wb_word);
      en_d   = 1'b1;
      we_d   = 4'hf;
    end else if (gnt_core) begin
      addr_d = word_addr(core_word);
      en_d   = 1'b1;
    end else if (gnt_feed) begin
      addr_d = word_addr(feed_word);
      en_d   = 1'b1;
    end

    if (req_feed && !gnt_feed) starve_d = feed_forced ? starve_q : starve_q + 1'b1;
    else                       starve_d = '0;

    rdx_d = rd_capture ? read_out_x : rdx_q;
    rdy_d = rd_capture ? read_out_y : rdy_q;
    rdz_d = rd_capture ? read_out_z : rdz_q;

    if (gnt_wb)           state_d = ST_WRITE;
    else if (gnt_rd)      state_d = ST_READ;
    else if (!pipe_empty) state_d = req_wb ? ST_DRAIN : ST_READ;
    else                  state_d = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= 4'h0;
      rdx_q    <= '0;
      rdy_q    <= '0;
      rdz_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      we_q     <= we_d;
      rdx_q    <= rdx_d;
      rdy_q    <= rdy_d;
      rdz_q    <= rdz_d;
    end
  end

  read_tag_pipe #(.READ_LATENCY(READ_LATENCY)) u_tags (
    .clock       (clock),
    .reset       (reset),
    .push_tag    (push_tag),
    .rd_capture  (rd_capture),
    .rvalid_core (rvalid_core),
    .rvalid_feed (rvalid_feed),
    .empty       (pipe_empty)
  );

  assign {addr_x, addr_y, addr_z} = {3{addr_q}};
  assign {en_x, en_y, en_z}       = {3{en_q}};
  assign {we_x, we_y, we_z}       = {3{we_q}};
  assign write_in_x = '0;
  assign write_in_y = '0;
  assign write_in_z = '0;
  assign {rst_x, rst_y, rst_z}    = 3'b000;
  assign rdata_x = rdx_q;
  assign rdata_y = rdy_q;
  assign rdata_z = rdz_q;
  assign busy    = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a scoreboard of expected BRAM
// accesses and read returns.
module tb_bram_port_arbiter;
  localparam int BW = 32;
  localparam int WW = 16;

  logic clock = 1'b0, reset = 1'b1, pause = 1'b0;
  logic req_core = 1'b0, req_feed = 1'b0, req_wb = 1'b0;
  logic [WW-1:0] core_word = '0, feed_word = '0, wb_word = '0;
  logic gnt_core, gnt_feed, gnt_wb;
  logic [31:0] addr_x, addr_y, addr_z;
  logic en_x, en_y, en_z;
  logic [3:0] we_x, we_y, we_z;
  logic [BW-1:0] write_in_x, write_in_y, write_in_z;
  logic rst_x, rst_y, rst_z;
  logic [BW-1:0] read_out_x, read_out_y, read_out_z;
  logic [BW-1:0] rdata_x, rdata_y, rdata_z;
  logic rvalid_core, rvalid_feed, busy;

  int cyc = 0, n_chk = 0, n_pass = 0, n_fail = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int          due;
    bit          is_core;
    bit          is_wr;
    logic [31:0] addr;
  } exp_t;
  exp_t acc_q[$];
  exp_t ret_q[$];

  bram_port_arbiter dut (
    .clock(clock), .reset(reset), .pause(pause),
    .req_core(req_core), .core_word(core_word), .gnt_core(gnt_core),
    .req_feed(req_feed), .feed_word(feed_word), .gnt_feed(gnt_feed),
    .req_wb(req_wb), .wb_word(wb_word), .gnt_wb(gnt_wb),
    .addr_x(addr_x), .addr_y(addr_y), .addr_z(addr_z),
    .en_x(en_x), .en_y(en_y), .en_z(en_z),
    .we_x(we_x), .we_y(we_y), .we_z(we_z),
    .write_in_x(write_in_x), .write_in_y(write_in_y), .write_in_z(write_in_z),
    .rst_x(rst_x), .rst_y(rst_y), .rst_z(rst_z),
    .read_out_x(read_out_x), .read_out_y(read_out_y), .read_out_z(read_out_z),
    .rdata_x(rdata_x), .rdata_y(rdata_y), .rdata_z(rdata_z),
    .rvalid_core(rvalid_core), .rvalid_feed(rvalid_feed), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input logic [31:0] a, input int ax);
    return (a * 32'h0000_9E37) ^ (32'h1111_0000 * (ax + 1));
  endfunction

  function automatic logic [31:0] wa(input logic [WW-1:0] w);
    return {14'b0, w, 2'b00};
  endfunction

  // Flow-through BRAM: data for the presented address is sampled at the next edge
  assign read_out_x = (en_x && we_x == 4'h0) ? pat(addr_x, 0) : 32'hDEAD_BEEF;
  assign read_out_y = (en_y && we_y == 4'h0) ? pat(addr_y, 1) : 32'hDEAD_BEEF;
  assign read_out_z = (en_z && we_z == 4'h0) ? pat(addr_z, 2) : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at +1 after the edge, check grants at +2, log expectations
  task automatic step(input logic rc, input logic [WW-1:0] cw, input logic rf,
                      input logic [WW-1:0] fw, input logic rw, input logic [WW-1:0] ww,
                      input logic p, input logic r, input logic [2:0] exp_g);
    @(posedge clock); #1;
    req_core = rc; core_word = cw; req_feed = rf; feed_word = fw;
    req_wb = rw; wb_word = ww; pause = p; reset = r;
    #1;
    check("grant", 128'({gnt_core, gnt_feed, gnt_wb}), 128'(exp_g));
    if (exp_g[2]) begin
      acc_q.push_back('{due: cyc + 1, is_core: 1'b1, is_wr: 1'b0, addr: wa(cw)});
      ret_q.push_back('{due: cyc + 2, is_core: 1'b1, is_wr: 1'b0, addr: wa(cw)});
    end
    if (exp_g[1]) begin
      acc_q.push_back('{due: cyc + 1, is_core: 1'b0, is_wr: 1'b0, addr: wa(fw)});
      ret_q.push_back('{due: cyc + 2, is_core: 1'b0, is_wr: 1'b0, addr: wa(fw)});
    end
    if (exp_g[0])
      acc_q.push_back('{due: cyc + 1, is_core: 1'b0, is_wr: 1'b1, addr: wa(ww)});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 3'b000);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (mon_on) begin
      if (acc_q.size() > 0 && acc_q[0].due == cyc) begin
        e = acc_q.pop_front();
        check("access", 128'({en_x, en_y, en_z, we_x, we_y, we_z, addr_x, addr_y, addr_z}),
              128'({3'b111, (e.is_wr ? 12'hfff : 12'h000), e.addr, e.addr, e.addr}));
        if (e.is_wr)
          check("wdata", 128'({write_in_x, write_in_y, write_in_z, rst_x, rst_y, rst_z}), 128'(0));
      end else begin
        check("no_access", 128'({en_x, en_y, en_z, we_x, we_y, we_z}), 128'(0));
      end
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        e = ret_q.pop_front();
        check("rvalid", 128'({rvalid_core, rvalid_feed}), 128'({e.is_core, !e.is_core}));
        check("rdata", 128'({rdata_x, rdata_y, rdata_z}),
              128'({pat(e.addr, 0), pat(e.addr, 1), pat(e.addr, 2)}));
      end else begin
        check("no_rvalid", 128'({rvalid_core, rvalid_feed}), 128'(0));
      end
    end
  end

  initial begin
    logic [WW-1:0] cw, fw;
    logic [2:0]    eg;

    // reset state
    step(0, 0, 0, 0, 0, 0, 0, 1, 3'b000);
    step(1, 4, 1, 4, 1, 4, 0, 1, 3'b000);
    check("reset_state", 128'({addr_x, en_x, we_x, rdata_x, rvalid_core, rvalid_feed, busy}), 128'(0));
    mon_on = 1'b1;

    // single core read of word 5
    step(1, 5, 0, 0, 0, 0, 0, 0, 3'b100);
    idle(1);
    check("busy_read", 128'(busy), 128'(1));
    idle(3);
    check("busy_idle", 128'(busy), 128'(0));

    // core and feed contend: feed forced after 8 denials
    cw = 16; fw = 40;
    for (int i = 0; i < 20; i++) begin
      eg = (i == 8 || i == 17) ? 3'b010 : 3'b100;
      step(1, cw, 1, fw, 0, 0, 0, 0, eg);
      if (eg == 3'b100) cw++;
      else fw++;
    end
    idle(3);

    // streaming reads, then write-back drains two in-flight reads
    for (int i = 0; i < 4; i++) step(1, WW'(50 + i), 0, 0, 0, 0, 0, 0, 3'b100);
    step(1, 54, 0, 0, 1, 3, 0, 0, 3'b000);
    step(1, 54, 0, 0, 1, 3, 0, 0, 3'b000);
    step(1, 54, 0, 0, 1, 3, 0, 0, 3'b001);
    step(1, 54, 0, 0, 0, 0, 0, 0, 3'b100);
    idle(3);

    // pause with two reads in flight; starvation still counts under pause
    step(1, 60, 0, 0, 0, 0, 0, 0, 3'b100);
    step(1, 61, 0, 0, 0, 0, 0, 0, 3'b100);
    for (int i = 0; i < 9; i++) begin
      step(1, 62, 1, 70, 0, 0, 1, 0, 3'b000);
      if (i == 0) check("busy_paused", 128'(busy), 128'(1));
      if (i == 3) check("busy_settled", 128'(busy), 128'(0));
    end
    step(1, 62, 1, 70, 0, 0, 0, 0, 3'b010);
    step(1, 62, 0, 0, 0, 0, 0, 0, 3'b100);
    idle(3);

    // reset the cycle after a feed grant
    step(0, 0, 1, 7, 0, 0, 0, 0, 3'b010);
    step(1, 9, 0, 0, 0, 0, 0, 1, 3'b000);
    ret_q.delete();
    idle(1);
    check("post_reset", 128'({addr_x, en_x, busy}), 128'(0));
    idle(2);

    // back-to-back write-backs, then a feed read with no bubble
    step(0, 0, 0, 0, 1, 1, 0, 0, 3'b001);
    step(0, 0, 0, 0, 1, 2, 0, 0, 3'b001);
    step(0, 0, 0, 0, 1, 3, 0, 0, 3'b001);
    step(0, 0, 1, 9, 0, 0, 0, 0, 3'b010);
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
